sideset_delay: RTL and testbench
================================

SIDESET_DELAY -- requirements
Module: sideset_delay

Interface
REQ-001 SHALL have parameter MAX_SS, default 5, meaning width of side-set/delay field (instr[12:8]).
REQ-002 SHALL have ports:
- pclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  clock-divider enable; state advances only when high
- instr_valid  in  1  decoded instruction present this cycle
- instr_stall  in  1  instruction cannot complete this cycle (wait/blocking)
- delay  in  5  decoded delay count
- side_set  in  5  decoded side-set field, right-aligned
- sideset_bits  in  3  side-set field width, including optional enable bit
- sideset_opt  in  1  MSB of side-set field is an enable bit
- sideset_pindirs  in  1  side-set targets pindirs (1) or pins (0)
- retire  out  1  instruction completes this cycle; PC may advance
- busy  out  1  delay in progress; fetch/decode held
- ss_pins_we  out  1  side-set write strobe to pins
- ss_dirs_we  out  1  side-set write strobe to pindirs
- ss_val  out  5  side-set value, right-aligned
- ss_mask  out  5  bits of ss_val that are valid

Function
REQ-003 SHALL implement states IDLE and DELAY with a 5-bit down-counter cnt.
REQ-004 With en low, state, cnt, and the first-cycle flag SHALL hold, and retire, ss_pins_we, and ss_dirs_we SHALL be 0.
REQ-005 In IDLE with en and instr_valid, side-set SHALL be applied on the first cycle of the instruction only, tracked by a flag that is cleared on retire; it SHALL be applied even if instr_stall is high.
REQ-006 Effective width SHALL be n = min(sideset_bits, 5); n = 0 SHALL produce no strobe.
REQ-007 With the option active and sideset_opt=1, side_set[n-1] SHALL gate the strobe, ss_val = side_set[n-2:0], and ss_mask = (1<<(n-1))-1; n = 1 in this case SHALL produce no strobe.
REQ-008 Otherwise, ss_val = side_set & ((1<<n)-1) and ss_mask = (1<<n)-1.
REQ-009 The strobe SHALL be ss_dirs_we if sideset_pindirs=1, else ss_pins_we; never both.
REQ-010 In IDLE with en, instr_valid, and !instr_stall, retire SHALL pulse for 1 cycle in the same cycle (combinational, zero latency).
REQ-011 On retire with delay=0, the block SHALL stay in IDLE; with delay=d>0, it SHALL load cnt=d and enter DELAY.
REQ-012 In DELAY, busy=1, and each en cycle SHALL decrement cnt; at cnt=1 with en, the block SHALL return to IDLE, giving exactly d en-cycles of busy.
REQ-013 In DELAY, instr_valid and instr_stall SHALL be ignored; no retire and no side-set SHALL occur.
REQ-014 A stalled instruction SHALL NOT start the delay; the delay SHALL begin only after the retiring cycle.
REQ-015 delay=31 SHALL give 31 busy cycles with no wrap; cnt SHALL never underflow.

Reset
REQ-016 On reset: state=IDLE, cnt=0, first-cycle flag set, busy=0, retire=0, ss_pins_we=0, ss_dirs_we=0, ss_val=0, ss_mask=0.
REQ-017 Reset asserted mid-DELAY SHALL abort the delay; the next cycle after deassertion SHALL be IDLE with busy=0.
REQ-018 Reset SHALL take priority over en and all other inputs.

Configuration
REQ-019 Macro SIDESET_OPT_EN, when defined, SHALL compile in the optional-enable-bit handling of REQ-007.
REQ-020 Without SIDESET_OPT_EN, sideset_opt SHALL be ignored, every side-set SHALL be unconditional per REQ-008, and no enable-bit logic SHALL be synthesised.

Structure
REQ-021 A shared package SHALL hold the state encoding (IDLE=0, DELAY=1), the field-width constant 5, and the max-delay constant 31.
REQ-022 A combinational sub-module sideset_expand SHALL compute ss_val, ss_mask, and the enable from side_set, sideset_bits, and sideset_opt.
REQ-023 The counter and FSM SHALL reside in sideset_delay.

Verification
REQ-024 sideset_bits=2, opt=0, side_set=5'b00011, delay=0, valid, !stall -> 1 cycle: ss_pins_we=1, ss_val=3, ss_mask=3, retire=1, busy stays 0.
REQ-025 delay=3, !stall -> retire in cycle 0, busy=1 in cycles 1-3, IDLE in cycle 4; a valid instruction in cycles 1-3 is neither retired nor side-set.
REQ-026 stall high for 4 cycles, then low, sideset_bits=1 -> single strobe in cycle 0 only; retire in cycle 4.
REQ-027 SIDESET_OPT_EN defined, opt=1, sideset_bits=3, side_set=5'b00010 -> no strobe; side_set=5'b00110 -> ss_val=2, ss_mask=3.
REQ-028 delay=31 with en toggling every other cycle -> busy lasts 62 clocks; reset asserted after 10 clocks -> busy=0 and IDLE on the cycle after reset.

Source files
------------

// File: rtl/sideset_delay_pkg.sv
// Shared constants and state encoding for the side-set / delay block.
// Used by sideset_delay and sideset_expand.
package sideset_delay_pkg;

    localparam int SS_W      = 5;   // side-set / delay field width
    localparam int MAX_DELAY = 31;  // largest encodable delay
    localparam int DLY_W     = $clog2(MAX_DELAY + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DELAY = 1'b1
    } state_t;

endpackage

// File: rtl/sideset_expand.sv
// Combinational decode of the side-set field into value, valid-bit mask and enable.
// Optional enable-bit handling is compiled in only with SIDESET_OPT_EN defined.
import sideset_delay_pkg::*;

module sideset_expand #(
    parameter int MAX_SS = SS_W
) (
    input  logic [MAX_SS-1:0] side_set,
    input  logic [2:0]        sideset_bits,
    input  logic              sideset_opt,
    output logic [MAX_SS-1:0] ss_val,
    output logic [MAX_SS-1:0] ss_mask,
    output logic              ss_en
);

    int n;

`ifndef SIDESET_OPT_EN
    logic unused_opt;
    assign unused_opt = sideset_opt;
`endif

    always_comb begin
        n       = (int'(sideset_bits) > MAX_SS) ? MAX_SS : int'(sideset_bits);
        ss_mask = '0;
        ss_en   = 1'b0;
`ifdef SIDESET_OPT_EN
        if (sideset_opt) begin
            // Top bit of the field gates the write; it is not part of the value.
            for (int i = 0; i < MAX_SS; i++) begin
                if (i < n - 1)
                    ss_mask[i] = 1'b1;
                if (n >= 2 && i == n - 1)
                    ss_en = side_set[i];
            end
        end else begin
            for (int i = 0; i < MAX_SS; i++)
                if (i < n)
                    ss_mask[i] = 1'b1;
            ss_en = (n != 0);
        end
`else
        for (int i = 0; i < MAX_SS; i++)
            if (i < n)
                ss_mask[i] = 1'b1;
        ss_en = (n != 0);
`endif
        ss_val = side_set & ss_mask;
    end

endmodule

// File: rtl/sideset_delay.sv
// Side-set application and post-instruction delay counter (IDLE/DELAY FSM).
// Define SIDESET_OPT_EN to honour the optional side-set enable bit.
import sideset_delay_pkg::*;

module sideset_delay #(
    parameter int MAX_SS = SS_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              en,
    input  logic              instr_valid,
    input  logic              instr_stall,
    input  logic [DLY_W-1:0]  delay,
    input  logic [MAX_SS-1:0] side_set,
    input  logic [2:0]        sideset_bits,
    input  logic              sideset_opt,
    input  logic              sideset_pindirs,
    output logic              retire,
    output logic              busy,
    output logic              ss_pins_we,
    output logic              ss_dirs_we,
    output logic [MAX_SS-1:0] ss_val,
    output logic [MAX_SS-1:0] ss_mask
);

    state_t            state;
    logic [DLY_W-1:0]  cnt;
    logic              first;

    logic [MAX_SS-1:0] exp_val;
    logic [MAX_SS-1:0] exp_mask;
    logic              exp_en;

    logic              issue;
    logic              apply;
    logic              strobe;

    sideset_expand #(.MAX_SS(MAX_SS)) u_expand (
        .side_set     (side_set),
        .sideset_bits (sideset_bits),
        .sideset_opt  (sideset_opt),
        .ss_val       (exp_val),
        .ss_mask      (exp_mask),
        .ss_en        (exp_en)
    );

    // Outputs are combinational so retire and side-set land in the issuing cycle.
    always_comb begin
        issue      = !reset && en && (state == IDLE) && instr_valid;
        apply      = issue && first;
        strobe     = apply && exp_en;
        retire     = issue && !instr_stall;
        busy       = !reset && (state == DELAY);
        ss_pins_we = strobe && !sideset_pindirs;
        ss_dirs_we = strobe && sideset_pindirs;
        ss_val     = strobe ? exp_val  : '0;
        ss_mask    = strobe ? exp_mask : '0;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            first <= 1'b1;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (retire) begin
                        first <= 1'b1;
                        if (delay != '0) begin
                            cnt   <= delay;
                            state <= DELAY;
                        end
                    end else if (apply) begin
                        first <= 1'b0;
                    end
                end
                DELAY: begin
                    // Leave on the last count; <= guards against ever underflowing.
                    if (cnt <= DLY_W'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sideset_delay.sv
// Directed bench for sideset_delay: side-set decode, retire timing, delays and reset.
module tb_sideset_delay;

    logic       pclk = 1'b0;
    logic       reset;
    logic       en;
    logic       instr_valid;
    logic       instr_stall;
    logic [4:0] delay;
    logic [4:0] side_set;
    logic [2:0] sideset_bits;
    logic       sideset_opt;
    logic       sideset_pindirs;
    logic       retire;
    logic       busy;
    logic       ss_pins_we;
    logic       ss_dirs_we;
    logic [4:0] ss_val;
    logic [4:0] ss_mask;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    sideset_delay dut (
        .pclk            (pclk),
        .reset           (reset),
        .en              (en),
        .instr_valid     (instr_valid),
        .instr_stall     (instr_stall),
        .delay           (delay),
        .side_set        (side_set),
        .sideset_bits    (sideset_bits),
        .sideset_opt     (sideset_opt),
        .sideset_pindirs (sideset_pindirs),
        .retire          (retire),
        .busy            (busy),
        .ss_pins_we      (ss_pins_we),
        .ss_dirs_we      (ss_dirs_we),
        .ss_val          (ss_val),
        .ss_mask         (ss_mask)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Check the full output set of the current cycle.
    task automatic chk_all(input string tag, input int r, input int b, input int pw,
                           input int dw, input int v, input int m);
        #1;
        chk({tag, ".retire"}, int'(retire), r);
        chk({tag, ".busy"},   int'(busy),   b);
        chk({tag, ".pins_we"}, int'(ss_pins_we), pw);
        chk({tag, ".dirs_we"}, int'(ss_dirs_we), dw);
        chk({tag, ".val"},    int'(ss_val),  v);
        chk({tag, ".mask"},   int'(ss_mask), m);
    endtask

    int busy_cnt;

    initial begin
        reset = 1'b1; en = 1'b1; instr_valid = 1'b1; instr_stall = 1'b0;
        delay = 5'd0; side_set = 5'b00011; sideset_bits = 3'd2;
        sideset_opt = 1'b0; sideset_pindirs = 1'b0;
        tick(); tick();
        // Reset dominates a valid instruction with en high.
        chk_all("rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Basic 2-bit side-set to pins, no delay.
        chk_all("ss2", 1, 0, 1, 0, 3, 3);
        tick();
        instr_valid = 1'b0;
        chk_all("ss2_after", 0, 0, 0, 0, 0, 0);

        // Width clamps to 5, pindirs target.
        instr_valid = 1'b1; sideset_bits = 3'd7; side_set = 5'b10101; sideset_pindirs = 1'b1;
        chk_all("dirs5", 1, 0, 0, 1, 21, 31);
        tick();
        // Width 0: retires but no strobe.
        sideset_bits = 3'd0; sideset_pindirs = 1'b0;
        chk_all("w0", 1, 0, 0, 0, 0, 0);
        tick();
        // en low: nothing happens.
        en = 1'b0; sideset_bits = 3'd3; side_set = 5'b00101;
        chk_all("en0", 0, 0, 0, 0, 0, 0);
        tick();
        en = 1'b1;
        chk_all("en1", 1, 0, 1, 0, 5, 7);
        tick();

        // Delay 3: busy in cycles 1..3, instructions there ignored.
        sideset_bits = 3'd2; side_set = 5'b00011; delay = 5'd3;
        chk_all("d3_c0", 1, 0, 1, 0, 3, 3);
        tick();
        delay = 5'd0;
        for (int c = 1; c <= 3; c++) begin
            chk_all($sformatf("d3_c%0d", c), 0, 1, 0, 0, 0, 0);
            tick();
        end
        chk_all("d3_c4", 1, 0, 1, 0, 3, 3);
        tick();

        // Stall 4 cycles: strobe only in cycle 0, retire in cycle 4, then delay 2.
        instr_stall = 1'b1; sideset_bits = 3'd1; side_set = 5'b00001; delay = 5'd2;
        chk_all("st_c0", 0, 0, 1, 0, 1, 1);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk_all($sformatf("st_c%0d", c), 0, 0, 0, 0, 0, 0);
            tick();
        end
        instr_stall = 1'b0;
        chk_all("st_c4", 1, 0, 0, 0, 0, 0);
        tick();
        instr_valid = 1'b0; delay = 5'd0;
        chk_all("st_c5", 0, 1, 0, 0, 0, 0);
        tick();
        chk_all("st_c6", 0, 1, 0, 0, 0, 0);
        tick();
        chk_all("st_c7", 0, 0, 0, 0, 0, 0);

        // Enable-bit option: only meaningful when compiled in.
        instr_valid = 1'b1; sideset_opt = 1'b1; sideset_bits = 3'd3; side_set = 5'b00010;
`ifdef SIDESET_OPT_EN
        chk_all("opt_off", 1, 0, 0, 0, 0, 0);
        tick();
        side_set = 5'b00110;
        chk_all("opt_on", 1, 0, 1, 0, 2, 3);
        tick();
        sideset_bits = 3'd1; side_set = 5'b00001;
        chk_all("opt_n1", 1, 0, 0, 0, 0, 0);
`else
        chk_all("opt_ign", 1, 0, 1, 0, 2, 7);
        tick();
        side_set = 5'b00110;
        chk_all("opt_ign2", 1, 0, 1, 0, 6, 7);
        tick();
        sideset_bits = 3'd1; side_set = 5'b00001;
        chk_all("opt_ign3", 1, 0, 1, 0, 1, 1);
`endif
        tick();
        sideset_opt = 1'b0;

        // Delay 31 with en always high: exactly 31 busy cycles.
        delay = 5'd31; sideset_bits = 3'd0;
        chk_all("d31_c0", 1, 0, 0, 0, 0, 0);
        tick();
        instr_valid = 1'b0; delay = 5'd0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (busy) busy_cnt++;
            tick();
        end
        chk("d31_busy", busy_cnt, 31);

        // Delay 31 with en high only on even cycles: 62 busy clocks.
        instr_valid = 1'b1; delay = 5'd31;
        chk_all("d31h_c0", 1, 0, 0, 0, 0, 0);
        tick();
        instr_valid = 1'b0; delay = 5'd0;
        busy_cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            en = (k % 2 == 0);
            #1;
            if (busy) busy_cnt++;
            tick();
        end
        en = 1'b1;
        chk("d31h_busy", busy_cnt, 62);

        // Reset 10 clocks into a 31 delay aborts it.
        instr_valid = 1'b1; delay = 5'd31;
        chk_all("rd_c0", 1, 0, 0, 0, 0, 0);
        tick();
        instr_valid = 1'b0; delay = 5'd0;
        for (int k = 1; k <= 10; k++) tick();
        chk_all("rd_busy", 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        chk_all("rd_rst", 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0; instr_valid = 1'b1; sideset_bits = 3'd2; side_set = 5'b00010;
        chk_all("rd_after", 1, 0, 1, 0, 2, 3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
